// File: rtl/path_tracer_pkg.sv
// Shared constants for the path tracer: default sizing, the unvisited
// marker, trace error codes and FSM state encodings.
// Optional feature macro used by this slice: PATH_TRACER_REVERSE_EN.

`ifndef PATH_TRACER_PKG_DEFINES
`define PATH_TRACER_PKG_DEFINES
`define DEFAULT_MAX_NODES   8
`define DEFAULT_INDEX_WIDTH 4
// All-ones in whatever width it lands in; a prev slot holding this was never reached.
`define UNVISITED           '1
`define PT_ERR_NONE         2'b00
`define PT_ERR_RANGE        2'b01
`define PT_ERR_UNVISITED    2'b10
`define PT_ERR_CYCLE        2'b11
`endif

package path_tracer_pkg;

  localparam int DEFAULT_MAX_NODES   = `DEFAULT_MAX_NODES;
  localparam int DEFAULT_INDEX_WIDTH = `DEFAULT_INDEX_WIDTH;

  localparam logic [1:0] PT_ERR_NONE      = `PT_ERR_NONE;
  localparam logic [1:0] PT_ERR_RANGE     = `PT_ERR_RANGE;
  localparam logic [1:0] PT_ERR_UNVISITED = `PT_ERR_UNVISITED;
  localparam logic [1:0] PT_ERR_CYCLE     = `PT_ERR_CYCLE;

  // PT_POP is only reachable when the reversed-order feature is built in.
  typedef enum logic [2:0] {
    PT_IDLE   = 3'd0,
    PT_CHECK  = 3'd1,
    PT_EMIT   = 3'd2,
    PT_FINISH = 3'd3,
    PT_POP    = 3'd4
  } pt_state_e;

endpackage

// File: rtl/path_tracer_stack.sv
// path_stack: small LIFO holding path nodes so they can be replayed
// source-first. Only instantiated when PATH_TRACER_REVERSE_EN is defined.
// dout always shows the top entry (0 when empty); pop just discards it.

module path_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    sp;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  assign wr_idx  = AW'(sp);
  assign top_idx = AW'(sp - 1'b1);
  assign empty   = (sp == '0);
  assign full    = (sp == PW'(DEPTH));
  assign dout    = empty ? '0 : mem[top_idx];

  // Stack pointer and storage; push wins if both are requested.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= din;
      sp          <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

endmodule

// File: rtl/path_tracer.sv
// path_tracer: walks the prev-node vector from target back to source and
// streams each node over path_node/path_valid/path_ready.
// Handshake: path_valid rises with path_node and both hold unchanged until
// a cycle where path_ready is also high; that cycle is the transfer.
// Optional macro PATH_TRACER_REVERSE_EN: buffer the walk in a stack and
// stream source-first instead; on error nothing is streamed.

module path_tracer
  import path_tracer_pkg::*;
#(
  parameter int MAX_NODES   = DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [INDEX_WIDTH-1:0]         source_node,
  input  logic [INDEX_WIDTH-1:0]         target_node,
  input  logic [INDEX_WIDTH-1:0]         number_of_nodes,
  input  logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_flattened,
  output logic [INDEX_WIDTH-1:0]         path_node,
  output logic                           path_valid,
  input  logic                           path_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [1:0]                     error_code,
  output logic [INDEX_WIDTH:0]           path_length,
  output pt_state_e                      debug_state
);

  localparam logic [INDEX_WIDTH-1:0] UNVISITED = `UNVISITED;
  localparam logic [INDEX_WIDTH:0]   MAX_N     = (INDEX_WIDTH+1)'(MAX_NODES);

  pt_state_e              state;
  logic [INDEX_WIDTH-1:0] src_q;
  logic [INDEX_WIDTH-1:0] n_q;
  logic [INDEX_WIDTH-1:0] cur;
  logic [INDEX_WIDTH-1:0] prev_cur;
  logic [INDEX_WIDTH:0]   count;
  logic                   range_err;
  logic                   cycle_err;
  logic                   unv_err;

  assign busy        = (state != PT_IDLE);
  assign debug_state = state;

  // Select prev[cur]; slots beyond MAX_NODES read as 0 and are rejected by range_err.
  always_comb begin
    prev_cur = '0;
    for (int j = 0; j < MAX_NODES; j++) begin
      if ({1'b0, cur} == (INDEX_WIDTH+1)'(j))
        prev_cur = prev_vector_flattened[INDEX_WIDTH*j +: INDEX_WIDTH];
    end
  end

`ifdef PATH_TRACER_REVERSE_EN
  logic                   stack_push;
  logic                   stack_pop;
  logic [INDEX_WIDTH-1:0] stack_dout;
  logic                   stack_empty;
  logic                   stack_full;

  // Push every node that passes CHECK; pop when loading the output register,
  // and drain leftovers in FINISH after an aborted walk.
  assign stack_push = (state == PT_CHECK) && !range_err && !cycle_err && !unv_err;
  assign stack_pop  = !stack_empty &&
                      (((state == PT_POP) && (!path_valid || path_ready)) ||
                       (state == PT_FINISH));

  path_stack #(
    .DEPTH (MAX_NODES),
    .WIDTH (INDEX_WIDTH)
  ) u_stack (
    .clock (clock),
    .reset (reset),
    .push  (stack_push),
    .pop   (stack_pop),
    .din   (cur),
    .dout  (stack_dout),
    .empty (stack_empty),
    .full  (stack_full)
  );
`endif

  // CHECK conditions, highest priority first. A cur beyond the physical
  // vector is treated as out of range even if number_of_nodes allows it.
  assign range_err = (cur >= n_q) || (src_q >= n_q) || ({1'b0, cur} >= MAX_N);
`ifdef PATH_TRACER_REVERSE_EN
  assign cycle_err = (count == {1'b0, n_q}) || stack_full;
`else
  assign cycle_err = (count == {1'b0, n_q});
`endif
  assign unv_err   = (cur != src_q) && (prev_cur == UNVISITED);

  // Trace controller: all outputs are registered here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= PT_IDLE;
      src_q       <= '0;
      n_q         <= '0;
      cur         <= '0;
      count       <= '0;
      path_node   <= '0;
      path_valid  <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      error_code  <= PT_ERR_NONE;
      path_length <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        PT_IDLE: begin
          if (start) begin
            src_q       <= source_node;
            n_q         <= number_of_nodes;
            cur         <= target_node;
            count       <= '0;
            error       <= 1'b0;
            error_code  <= PT_ERR_NONE;
            path_length <= '0;
            state       <= PT_CHECK;
          end
        end
        PT_CHECK: begin
          if (range_err) begin
            error_code <= PT_ERR_RANGE;
            state      <= PT_FINISH;
          end else if (cycle_err) begin
            error_code <= PT_ERR_CYCLE;
            state      <= PT_FINISH;
          end else if (unv_err) begin
            error_code <= PT_ERR_UNVISITED;
            state      <= PT_FINISH;
          end else begin
`ifdef PATH_TRACER_REVERSE_EN
            // Node pushed this cycle; keep walking without a handshake.
            count <= count + 1'b1;
            if (cur == src_q) state <= PT_POP;
            else              cur   <= prev_cur;
`else
            path_valid <= 1'b1;
            path_node  <= cur;
            state      <= PT_EMIT;
`endif
          end
        end
        PT_EMIT: begin
          if (path_ready) begin
            path_valid <= 1'b0;
            count      <= count + 1'b1;
            if (cur == src_q) begin
              state <= PT_FINISH;
            end else begin
              cur   <= prev_cur;
              state <= PT_CHECK;
            end
          end
        end
`ifdef PATH_TRACER_REVERSE_EN
        PT_POP: begin
          if (!path_valid) begin
            path_valid <= 1'b1;
            path_node  <= stack_dout;
          end else if (path_ready) begin
            if (stack_empty) begin
              path_valid <= 1'b0;
              state      <= PT_FINISH;
            end else begin
              path_node <= stack_dout;
            end
          end
        end
        PT_FINISH: begin
          if (stack_empty) begin
            done        <= 1'b1;
            path_length <= (error_code != PT_ERR_NONE) ? '0 : count;
            error       <= (error_code != PT_ERR_NONE);
            state       <= PT_IDLE;
          end
        end
`else
        PT_FINISH: begin
          done        <= 1'b1;
          path_length <= count;
          error       <= (error_code != PT_ERR_NONE);
          state       <= PT_IDLE;
        end
`endif
        default: state <= PT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_path_tracer.sv
// Bench for path_tracer: directed scenarios plus randomized prev vectors,
// checked against a queue-based walk model of the trace rules.

module tb_path_tracer;
  import path_tracer_pkg::*;

  localparam int MN  = DEFAULT_MAX_NODES;
  localparam int W   = DEFAULT_INDEX_WIDTH;
  localparam int UNV = (1 << W) - 1;

  logic              clock;
  logic              reset;
  logic              start;
  logic [W-1:0]      source_node;
  logic [W-1:0]      target_node;
  logic [W-1:0]      number_of_nodes;
  logic [W*MN-1:0]   prev_flat;
  logic [W-1:0]      path_node;
  logic              path_valid;
  logic              path_ready;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        error_code;
  logic [W:0]        path_length;
  pt_state_e         debug_state;

  int compared;
  int mismatched;
  logic [W-1:0] exp_q[$];
  int prev_a[MN];

  path_tracer dut (
    .clock                 (clock),
    .reset                 (reset),
    .start                 (start),
    .source_node           (source_node),
    .target_node           (target_node),
    .number_of_nodes       (number_of_nodes),
    .prev_vector_flattened (prev_flat),
    .path_node             (path_node),
    .path_valid            (path_valid),
    .path_ready            (path_ready),
    .busy                  (busy),
    .done                  (done),
    .error                 (error),
    .error_code            (error_code),
    .path_length           (path_length),
    .debug_state           (debug_state)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: follow prev links from the target, applying the trace rules.
  task automatic model(input int src, input int tgt, input int n,
                       output int code, output int len);
    int cur;
    exp_q.delete();
    code = 0;
    cur  = tgt;
    while (1) begin
      if (cur >= n || src >= n || cur >= MN) begin code = 1; break; end
      if (exp_q.size() == n) begin code = 3; break; end
      if (cur != src && prev_a[cur] == UNV) begin code = 2; break; end
      exp_q.push_back(W'(cur));
      if (cur == src) break;
      cur = prev_a[cur];
    end
`ifdef PATH_TRACER_REVERSE_EN
    if (code != 0) begin
      exp_q.delete();
    end else begin
      logic [W-1:0] tmp[$];
      foreach (exp_q[i]) tmp.push_front(exp_q[i]);
      exp_q = tmp;
    end
`endif
    len = exp_q.size();
  endtask

  task automatic pack_prev();
    for (int j = 0; j < MN; j++) prev_flat[W*j +: W] = prev_a[j][W-1:0];
  endtask

  // Driver + monitor for one trace. mode 0: ready=1, 1: random ready,
  // 2: ready held low 10 cycles while the second node is offered.
  task automatic run_trace(input string tag, input int src, input int tgt,
                           input int n, input int mode);
    int code, len, cycles, first_valid, got, stall;
    bit finished, hold_valid;
    logic [W-1:0] hold_node;
    model(src, tgt, n, code, len);
    @(negedge clock);
    source_node     = W'(src);
    target_node     = W'(tgt);
    number_of_nodes = W'(n);
    pack_prev();
    start      = 1'b1;
    path_ready = (mode == 0);
    @(negedge clock);
    start = 1'b0;
    cycles = 1; first_valid = -1; got = 0; stall = 0;
    finished = 0; hold_valid = 0; hold_node = '0;
    while (!finished && cycles < 400) begin
      if (hold_valid) begin
        check({tag, "_hold_valid"}, 32'(path_valid), 32'd1);
        check({tag, "_hold_node"}, 32'(path_node), 32'(hold_node));
      end
      if (path_valid && first_valid < 0) first_valid = cycles;
      if (done) begin
        finished = 1;
      end else begin
        case (mode)
          0: path_ready = 1'b1;
          1: path_ready = 1'($urandom_range(0, 1));
          default: begin
            if (path_valid && got == 1 && stall < 10) begin
              path_ready = 1'b0;
              stall++;
            end else begin
              path_ready = 1'b1;
            end
          end
        endcase
        if (path_valid && path_ready) begin
          if (exp_q.size() > 0) check({tag, "_node"}, 32'(path_node), 32'(exp_q.pop_front()));
          got++;
        end
        hold_valid = path_valid && !path_ready;
        hold_node  = path_node;
        @(negedge clock);
        cycles++;
      end
    end
    check({tag, "_done_seen"}, 32'(finished), 32'd1);
    check({tag, "_nodes"}, 32'(got), 32'(len));
    check({tag, "_length"}, 32'(path_length), 32'(len));
    check({tag, "_error"}, 32'(error), 32'(code != 0));
    check({tag, "_code"}, 32'(error_code), 32'(code));
    check({tag, "_busy"}, 32'(busy), 32'd0);
`ifndef PATH_TRACER_REVERSE_EN
    check({tag, "_latency"}, 32'(first_valid), (len > 0) ? 32'd2 : 32'hffffffff);
`endif
    if (mode == 2) check({tag, "_stalled"}, 32'(stall), 32'd10);
    @(negedge clock);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic set_chain();
    for (int j = 0; j < MN; j++) prev_a[j] = UNV;
    prev_a[0] = 0; prev_a[1] = 0; prev_a[2] = 1; prev_a[3] = 2; prev_a[4] = 3;
  endtask

  initial begin
    int n, src, tgt, mode;
    compared = 0; mismatched = 0;
    reset = 1'b1; start = 1'b0; path_ready = 1'b0;
    source_node = '0; target_node = '0; number_of_nodes = '0; prev_flat = '0;
    for (int j = 0; j < MN; j++) prev_a[j] = UNV;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(path_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_code", 32'(error_code), 32'd0);
    check("rst_length", 32'(path_length), 32'd0);
    check("rst_node", 32'(path_node), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Directed scenarios
    set_chain();
    run_trace("chain", 0, 4, 5, 0);
    run_trace("same", 2, 2, 5, 0);
    set_chain(); prev_a[3] = UNV;
    run_trace("unvisited", 0, 4, 5, 0);
    for (int j = 0; j < MN; j++) prev_a[j] = UNV;
    prev_a[0] = 0; prev_a[1] = 2; prev_a[2] = 1; prev_a[3] = 2;
    run_trace("cycle", 0, 3, 4, 0);
    set_chain();
    run_trace("range_tgt", 0, 7, 5, 0);
    run_trace("range_n0", 0, 0, 0, 0);
    run_trace("range_src", 6, 2, 5, 0);
    run_trace("stall", 0, 4, 5, 2);
    run_trace("rand_ready", 0, 4, 5, 1);

    // Reset in the middle of a walk: aborts at once, no done pulse
    @(negedge clock);
    source_node = '0; target_node = 4'd4; number_of_nodes = 4'd5; pack_prev();
    start = 1'b1; path_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("midrst_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(path_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("midrst_done", 32'(done), 32'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    check("midrst_idle", 32'(debug_state), 32'(PT_IDLE));
    check("midrst_done_after", 32'(done), 32'd0);
    run_trace("after_rst", 1, 3, 5, 0);

    // Randomized vectors
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(0, MN);
      for (int j = 0; j < MN; j++) begin
        if (j >= n || $urandom_range(0, 7) == 0) prev_a[j] = UNV;
        else if ($urandom_range(0, 3) != 0)      prev_a[j] = $urandom_range(0, j);
        else                                      prev_a[j] = $urandom_range(0, n - 1);
      end
      src  = $urandom_range(0, MN + 1);
      tgt  = $urandom_range(0, MN + 1);
      mode = $urandom_range(0, 1);
      run_trace("random", src, tgt, n, mode);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/path_tracer.md
Name: path_tracer

Overview:
- Reader side of the visited store.
- After the search completes, walks the prev-node vector backwards from a target node to the source node.
- Streams each path node out over a valid/ready handshake, then reports the path length and completion status.
- Sits between the visited store's prev_vector_flattened output and the result/output logic of the Dijkstra core.

Parameters:
- MAX_NODES, `DEFAULT_MAX_NODES, number of node slots in the prev vector.
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH, width of a node index; `UNVISITED is an INDEX_WIDTH-wide value.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a trace; sampled only in IDLE.
- source_node  in  INDEX_WIDTH  search origin.
- target_node  in  INDEX_WIDTH  path destination.
- number_of_nodes  in  INDEX_WIDTH  active node count.
- prev_vector_flattened  in  INDEX_WIDTH*MAX_NODES  slot j at bits [INDEX_WIDTH*j +: INDEX_WIDTH].
- path_node  out  INDEX_WIDTH  current emitted node.
- path_valid  out  1  path_node is valid.
- path_ready  in  1  consumer accepts path_node.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a trace ends, whether success or error.
- error  out  1  sticky until the next start; high if the trace failed.
- error_code  out  2  00 none, 01 index out of range, 10 unvisited node on path, 11 hop limit (cycle).
- path_length  out  INDEX_WIDTH+1  count of nodes emitted; held until the next start.

Behaviour:
- Reset, asynchronous: state goes to IDLE and all outputs and internal registers go to 0.
- Reset mid-trace: the trace is aborted with no done pulse.

FSM states are IDLE, CHECK, EMIT, FINISH.

- IDLE:
  - On start=1, latch source, target and number_of_nodes.
  - Load cur<=target; clear count, error and error_code.
  - Go to CHECK on the next cycle.
  - start asserted while busy is ignored.
- CHECK, one cycle, checks evaluated in priority order:
  1. cur>=N or source>=N -> code 01, go to FINISH.
  2. count==N -> code 11, go to FINISH.
  3. cur!=source and prev[cur]==`UNVISITED -> code 10, go to FINISH.
  4. Otherwise go to EMIT.
  - prev[source] is never read; the walk stops at the source regardless of its slot value.
- EMIT:
  - path_valid=1 and path_node=cur; both are held stable until path_ready.
  - On the handshake (valid&ready): count<=count+1.
  - If cur==source, go to FINISH; else cur<=prev[cur] and go to CHECK.
- FINISH: done=1 for exactly one cycle; path_length<=count; error<=(code!=0); return to IDLE.

Timing and ordering:
- Emission order is target first, source last.
- Minimum throughput is 1 node per 2 cycles (CHECK + EMIT).
- Latency from start to first path_valid is 2 cycles.

Boundaries:
- source==target: emits one node, path_length=1.
- N==0: code 01.
- On an error, nodes already emitted remain counted in path_length.
- The path_ready backpressure duration is unbounded.

Optional Feature:
- Macro: PATH_TRACER_REVERSE_EN.
- Defined:
  - An internal MAX_NODES x INDEX_WIDTH stack is added.
  - During the walk, nodes are pushed with no handshake (1 node per cycle through CHECK).
  - A POP state then emits nodes source first, target last, over the same handshake.
  - On an error, nothing is emitted and path_length=0.
  - done fires after the last pop.
- Undefined: target-first streaming as described above, with no storage.

Decomposition:
- The shared constants file holds:
  - the `UNVISITED and `DEFAULT_* constants;
  - new `PT_ERR_NONE/`PT_ERR_RANGE/`PT_ERR_UNVISITED/`PT_ERR_CYCLE codes;
  - the FSM state encodings.
- One natural sub-module: path_stack, a LIFO used only under PATH_TRACER_REVERSE_EN.
  - Ports: clock, reset, push, pop, din, dout, empty, full.

Test Plan:
- N=5, prev={0,0,1,2,3}, src=0, tgt=4, ready tied 1 -> path_node 4,3,2,1,0; path_length=5; error=0; done one pulse.
- src=tgt=2, N=5 -> single node 2; path_length=1.
- N=5, prev[3]=`UNVISITED, tgt=4, prev[4]=3 -> emits 4, then error_code=10, path_length=1.
- N=4, prev={0,2,1,2}, src=0, tgt=3 (cycle 1<->2) -> error_code=11 after 4 emitted nodes.
- tgt=7 with N=5 -> error_code=01, no path_valid; ready held low 10 cycles mid-walk -> path_node stable; reset asserted mid-walk -> busy=0 immediately, no done.
- With PATH_TRACER_REVERSE_EN and the first scenario's vector -> emits 0,1,2,3,4.
